player_input_conditioner: RTL and testbench

//  Front-end stage that feeds the bomberman game core for one player.
//  - Conditions 5 raw controls: 2-flop synchroniser, then per-bit debounce.
//  - Emits one-cycle press pulses, plus a single priority-encoded command strobe.
//  - Two instances are used: player A on btnS/U/D/L/R, player B on JA-decoded keys.

---
 rtl/player_input_conditioner.sv | 110 +++++++++++
 tb/tb_player_input_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/player_input_conditioner.sv
// Per-player key front end: synchronise, debounce, press pulses, command strobe.
// Optional auto-repeat of held keys is built when AUTO_REPEAT_EN is defined.
module player_input_conditioner #(
    parameter int          DEB_CYCLES    = 10000,
    parameter int          REPEAT_CYCLES = 150000,
    parameter logic [4:0]  REPEAT_MASK   = 5'b11110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] press,
    output logic       cmd_valid,
    output logic [2:0] cmd
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [DW-1:0] cnt [5];
    logic [4:0]    rise;
    logic [4:0]    rep_hit;
    logic [4:0]    press_next;
    logic [2:0]    code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_deb
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt[i]       <= '0;
                btn_level[i] <= 1'b0;
            end else if (sync2[i] == btn_level[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
                btn_level[i] <= sync2[i];
                cnt[i]       <= '0;
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end

        assign rise[i] = sync2[i] & ~btn_level[i] & (cnt[i] == DEB_LAST);
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    for (genvar i = 0; i < 5; i++) begin : g_rep
        if (REPEAT_MASK[i]) begin : g_on
            logic [RW-1:0] rep_cnt;

            // Level is still low on the initial-press edge, so that clears too.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rep_cnt <= '0;
                end else if (!btn_level[i] || rep_cnt == REP_LAST) begin
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end

            assign rep_hit[i] = btn_level[i] & (rep_cnt == REP_LAST);
        end else begin : g_off
            assign rep_hit[i] = 1'b0;
        end
    end
`else
    logic unused_rep;

    assign unused_rep = ^{REPEAT_MASK, 32'(REPEAT_CYCLES)};
    assign rep_hit    = '0;
`endif

    assign press_next = rise | rep_hit;

    always_comb begin
        code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (press[i]) begin
                code = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press     <= '0;
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else begin
            press     <= press_next;
            cmd_valid <= |press;
            cmd       <= code;
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Directed bench for player_input_conditioner with DEB_CYCLES=4, REPEAT_CYCLES=8.
// Expected repeat pulses follow AUTO_REPEAT_EN when the bench is built with it.
module tb_player_input_conditioner;

`ifdef AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam logic [4:0] MASK = 5'b11110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] press;
    logic       cmd_valid;
    logic [2:0] cmd;

    int         vectors = 0;
    int         miscompares = 0;
    logic [4:0] prev_p;

    player_input_conditioner #(
        .DEB_CYCLES   (4),
        .REPEAT_CYCLES(8),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .press    (press),
        .cmd_valid(cmd_valid),
        .cmd      (cmd)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] enc(input logic [4:0] p);
        if (p[0]) return 3'd1;
        if (p[1]) return 3'd2;
        if (p[2]) return 3'd3;
        if (p[3]) return 3'd4;
        if (p[4]) return 3'd5;
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, req);
            $error("%s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] l,
                           input logic [4:0] p, input logic v,
                           input logic [2:0] c);
        chk({tag, ".level"}, {3'b0, btn_level}, {3'b0, l});
        chk({tag, ".press"}, {3'b0, press}, {3'b0, p});
        chk({tag, ".valid"}, {7'b0, cmd_valid}, {7'b0, v});
        chk({tag, ".cmd"}, {5'b0, cmd}, {5'b0, c});
    endtask

    task automatic edge_chk(input string tag, input logic [4:0] l,
                            input logic [4:0] p, input logic v,
                            input logic [2:0] c);
        @(posedge clk);
        #1;
        chk_all(tag, l, p, v, c);
    endtask

    task automatic quiet(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            edge_chk($sformatf("%s.e%0d", tag, k), 5'b0, 5'b0, 1'b0, 3'd0);
        end
    endtask

    // Caller is at a negedge; edge k is the k-th posedge after the raw change.
    task automatic hold_seq(input logic [4:0] keys, input int n,
                            input string tag);
        logic [4:0] lvl;
        logic [4:0] p;
        btn_raw = keys;
        prev_p  = '0;
        for (int k = 1; k <= n; k++) begin
            lvl = (k >= 6) ? keys : 5'b0;
            if (k == 6)
                p = keys;
            else if (REP && k > 6 && (k - 6) % 8 == 0)
                p = keys & MASK;
            else
                p = 5'b0;
            edge_chk($sformatf("%s.e%0d", tag, k), lvl, p, |prev_p,
                     enc(prev_p));
            prev_p = p;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst     = 1'b1;
        btn_raw = '0;
        #1;
        chk_all({tag, ".now"}, 5'b0, 5'b0, 1'b0, 3'd0);
        quiet(2, {tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
        quiet(2, {tag, ".idle"});
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        prev_p  = '0;
        #3;
        chk_all("reset", 5'b0, 5'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet(3, "idle");

        // Down press, then release before any repeat could land.
        @(negedge clk);
        hold_seq(5'b00100, 7, "down");
        @(negedge clk);
        btn_raw = '0;
        for (int k = 1; k <= 7; k++) begin
            edge_chk($sformatf("rel.e%0d", k),
                     (k < 6) ? 5'b00100 : 5'b00000, 5'b0,
                     |prev_p, enc(prev_p));
            prev_p = '0;
        end

        // Three-cycle glitch on up is rejected.
        @(negedge clk);
        btn_raw = 5'b00010;
        quiet(3, "glitch.hi");
        @(negedge clk);
        btn_raw = '0;
        quiet(10, "glitch.lo");

        // Bomb and right together: bomb wins, right is not queued.
        @(negedge clk);
        hold_seq(5'b10001, 16, "dual");
        do_reset("rst3");

        // Held left repeats if enabled; held bomb never does.
        @(negedge clk);
        hold_seq(5'b01000, 40, "left");
        do_reset("rst4a");
        @(negedge clk);
        hold_seq(5'b00001, 40, "bomb");
        do_reset("rst4b");

        // Reset mid-hold, then the held key is pressed again.
        @(negedge clk);
        hold_seq(5'b10000, 10, "right");
        rst = 1'b1;
        #1;
        chk_all("midrst.now", 5'b0, 5'b0, 1'b0, 3'd0);
        quiet(3, "midrst.held");
        @(negedge clk);
        rst = 1'b0;
        hold_seq(5'b10000, 8, "again");
        do_reset("rst5");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
